// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle logic/arith ALU plus iterative unsigned
// multiply (radix-2 shift-add) and divide (restoring), WIDTH iterations each.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready, x, y, op   request handshake and operands
//   out_valid       one-cycle completion pulse
//   r, hi           primary result / high product or remainder
//   zero, ovf, dbz, illegal   result flags (registered, held until next result)
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             dbz,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SRL  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_MULU = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_ADD  = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // a: high product / partial remainder; b: multiplier->low product,
  // dividend->quotient; m: multiplicand or divisor.
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic [WIDTH-1:0] r_q, r_d, hi_q, hi_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, dbz_q, dbz_d;
  logic             illegal_q, illegal_d, out_valid_q, out_valid_d;

  logic [WIDTH-1:0] alu_res, add_res, sub_res;
  logic             alu_ovf, alu_ill;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic             div_ge, accept, last;
  logic [WIDTH-1:0] mul_a, mul_b, div_a, div_b;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;
  assign illegal   = illegal_q;

  // Single-cycle datapath, evaluated straight off the request inputs.
  always_comb begin
    add_res = x + y;
    sub_res = x - y;
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (op)
      OP_AND:  alu_res = x & y;
      OP_OR:   alu_res = x | y;
      OP_NOR:  alu_res = ~(x | y);
      OP_SLL:  alu_res = x << y[SHW-1:0];
      OP_SRL:  alu_res = x >> y[SHW-1:0];
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (x < y)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_ADD: begin
        alu_res = add_res;
        alu_ovf = (x[WIDTH-1] == y[WIDTH-1]) && (add_res[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_ovf = (x[WIDTH-1] != y[WIDTH-1]) && (sub_res[WIDTH-1] != x[WIDTH-1]);
      end
      OP_MULU, OP_DIVU: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // One iteration of each multi-cycle engine.
  always_comb begin
    mul_sum = {1'b0, a_q} + (b_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    mul_a   = mul_sum[WIDTH:1];
    mul_b   = {mul_sum[0], b_q[WIDTH-1:1]};
    rem_sh  = {a_q, b_q[WIDTH-1]};
    div_ge  = rem_sh >= {1'b0, m_q};
    // When div_ge the true difference is < divisor, so it fits in WIDTH bits.
    div_a   = div_ge ? (rem_sh[WIDTH-1:0] - m_q) : rem_sh[WIDTH-1:0];
    div_b   = {b_q[WIDTH-2:0], div_ge};
    last    = (cnt_q == CW'(WIDTH-1));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    m_d         = m_q;
    r_d         = r_q;
    hi_d        = hi_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;
    illegal_d   = illegal_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        cnt_d = '0;
        a_d   = '0;
        if (op == OP_MULU) begin
          state_d = S_MUL;
          b_d     = y;
          m_d     = x;
        end else if (op == OP_DIVU && y != '0) begin
          state_d = S_DIV;
          b_d     = x;
          m_d     = y;
        end else if (op == OP_DIVU) begin
          out_valid_d = 1'b1;
          r_d         = '1;
          hi_d        = x;
          zero_d      = 1'b0;
          ovf_d       = 1'b0;
          dbz_d       = 1'b1;
          illegal_d   = 1'b0;
        end else begin
          out_valid_d = 1'b1;
          r_d         = alu_res;
          hi_d        = '0;
          zero_d      = (alu_res == '0);
          ovf_d       = alu_ovf;
          dbz_d       = 1'b0;
          illegal_d   = alu_ill;
        end
      end
      S_MUL, S_DIV: begin
        a_d   = (state_q == S_MUL) ? mul_a : div_a;
        b_d   = (state_q == S_MUL) ? mul_b : div_b;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b1;
          r_d         = b_d;
          hi_d        = a_d;
          zero_d      = (b_d == '0);
          ovf_d       = 1'b0;
          dbz_d       = 1'b0;
          illegal_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      r_q         <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      m_q         <= m_d;
      r_q         <= r_d;
      hi_q        <= hi_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x = '0, y = '0;
  logic [3:0]  op = '0;
  logic        out_valid;
  logic [31:0] r, hi;
  logic        zero, ovf, dbz, illegal;
  int total = 0;
  int bad   = 0;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .op(op), .out_valid(out_valid), .r(r), .hi(hi),
    .zero(zero), .ovf(ovf), .dbz(dbz), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; x = a; y = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++;
    if ({out_valid, in_ready, zero, ovf, dbz, illegal} !== 6'b0 || r !== 32'h0 || hi !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: ov=%b rdy=%b r=%h hi=%h flags=%b%b%b%b want all 0",
               out_valid, in_ready, r, hi, zero, ovf, dbz, illegal);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add_sub();
    drive(4'd15, 32'h7FFF_FFFF, 32'h1);
    total++;
    if (out_valid !== 1'b1 || r !== 32'h8000_0000 || ovf !== 1'b1 || zero !== 1'b0 || hi !== 32'h0) begin
      bad++;
      $display("FAIL add_ovf: ov=%b r=%h ovf=%b zero=%b hi=%h want 1 80000000 1 0 0", out_valid, r, ovf, zero, hi);
    end
    drive(4'd6, 32'd5, 32'd5);
    total++;
    if (out_valid !== 1'b1 || r !== 32'h0 || zero !== 1'b1 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL sub_zero: ov=%b r=%h zero=%b ovf=%b want 1 0 1 0", out_valid, r, zero, ovf);
    end
    drive(4'd15, 32'hFFFF_FFFF, 32'h1);
    total++;
    if (r !== 32'h0 || zero !== 1'b1 || ovf !== 1'b0) begin
      bad++; $display("FAIL add_wrap: r=%h zero=%b ovf=%b want 0 1 0", r, zero, ovf);
    end
    drive(4'd6, 32'h8000_0000, 32'h1);
    total++;
    if (r !== 32'h7FFF_FFFF || ovf !== 1'b1) begin
      bad++; $display("FAIL sub_ovf: r=%h ovf=%b want 7fffffff 1", r, ovf);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_no_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_logic();
    logic [3:0]  ops [5] = '{4'd0, 4'd1, 4'd12, 4'd2, 4'd3};
    logic [31:0] xs  [5] = '{32'hF0F0_1234, 32'hF000_0000, 32'h0, 32'h1, 32'h8000_0000};
    logic [31:0] ys  [5] = '{32'h0FF0_FFFF, 32'h0000_000F, 32'h0, 32'h21, 32'h1F};
    logic [31:0] exp [5] = '{32'h00F0_1234, 32'hF000_000F, 32'hFFFF_FFFF, 32'h2, 32'h1};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], xs[i], ys[i]);
      total++;
      if (out_valid !== 1'b1 || r !== exp[i] || hi !== 32'h0 || ovf !== 1'b0) begin
        bad++;
        $display("FAIL logic_op%0d: ov=%b r=%h hi=%h ovf=%b want 1 %h 0 0", ops[i], out_valid, r, hi, ovf, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    op = 4'd7; x = 32'hFFFF_FFFF; y = 32'h1; in_valid = 1'b1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0: got %b want 1", in_ready); end
    tick();
    op = 4'd8;
    total++;
    if (out_valid !== 1'b1 || r !== 32'h0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_sltu: ov=%b r=%h rdy=%b want 1 0 1", out_valid, r, in_ready);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || r !== 32'h1) begin
      bad++; $display("FAIL b2b_slt: ov=%b r=%h want 1 1", out_valid, r);
    end
  endtask

  task automatic test_mulu();
    int errs = 0;
    drive(4'd10, 32'hFFFF_FFFF, 32'h2);
    for (int i = 1; i <= 32; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) errs++;
      tick();
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL mulu_busy: %0d busy cycles wrong, want 0", errs); end
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || hi !== 32'h1 || r !== 32'hFFFF_FFFE || zero !== 1'b0) begin
      bad++;
      $display("FAIL mulu_result: ov=%b rdy=%b hi=%h r=%h zero=%b want 1 1 1 fffffffe 0", out_valid, in_ready, hi, r, zero);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || r !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL mulu_hold: ov=%b r=%h want 0 fffffffe", out_valid, r);
    end
  endtask

  task automatic test_divu();
    int errs = 0;
    drive(4'd11, 32'd100, 32'd7);
    for (int i = 1; i <= 32; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) errs++;
      tick();
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL divu_busy: %0d busy cycles wrong, want 0", errs); end
    total++;
    if (out_valid !== 1'b1 || r !== 32'd14 || hi !== 32'd2 || dbz !== 1'b0) begin
      bad++; $display("FAIL divu_result: ov=%b r=%0d hi=%0d dbz=%b want 1 14 2 0", out_valid, r, hi, dbz);
    end
    drive(4'd11, 32'd9, 32'd0);
    total++;
    if (out_valid !== 1'b1 || r !== 32'hFFFF_FFFF || hi !== 32'd9 || dbz !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL divu_dbz: ov=%b r=%h hi=%0d dbz=%b rdy=%b want 1 ffffffff 9 1 1", out_valid, r, hi, dbz, in_ready);
    end
  endtask

  task automatic test_reset_abort();
    int errs = 0;
    drive(4'd10, 32'd3, 32'd5);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    total++;
    if ({out_valid, in_ready, zero, ovf, dbz, illegal} !== 6'b0 || r !== 32'h0 || hi !== 32'h0) begin
      bad++;
      $display("FAIL abort_outputs: ov=%b rdy=%b r=%h hi=%h flags=%b%b%b%b want all 0",
               out_valid, in_ready, r, hi, zero, ovf, dbz, illegal);
    end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin bad++; $display("FAIL abort_no_valid: %0d stray pulses want 0", errs); end
    drive(4'd15, 32'd3, 32'd4);
    total++;
    if (out_valid !== 1'b1 || r !== 32'd7) begin
      bad++; $display("FAIL abort_add: ov=%b r=%0d want 1 7", out_valid, r);
    end
  endtask

  task automatic test_illegal();
    drive(4'd4, 32'hA5, 32'hA5);
    total++;
    if (out_valid !== 1'b1 || r !== 32'h0 || hi !== 32'h0 || zero !== 1'b1 || illegal !== 1'b1) begin
      bad++;
      $display("FAIL illegal_op4: ov=%b r=%h hi=%h zero=%b ill=%b want 1 0 0 1 1", out_valid, r, hi, zero, illegal);
    end
    drive(4'd0, 32'hFF, 32'h0F);
    total++;
    if (illegal !== 1'b0 || r !== 32'h0F) begin
      bad++; $display("FAIL illegal_clear: ill=%b r=%h want 0 f", illegal, r);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_back_to_back();
    test_mulu();
    test_divu();
    test_reset_abort();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
